// File: rtl/mixed_acc_pkg.sv
// Shared types and constants for the mixed-width accumulate sequencer.
// Holds the sequencer state enum, default operand widths and the
// saturation bound helpers used when MIXED_ACC_SATURATE_EN is defined.
package mixed_acc_pkg;

  localparam int IN_WIDTH_DEF  = 8;
  localparam int OUT_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_e;

  // Largest positive value of a w-bit two's-complement number (w <= 64).
  function automatic logic [63:0] sat_max64(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative value of a w-bit two's-complement number, in the low w bits.
  function automatic logic [63:0] sat_min64(input int w);
    return ~sat_max64(w);
  endfunction

endpackage

// File: rtl/mixed_int_adder.sv
// Mixed-width adder: sign-extends a short signed operand and adds it to a
// wide signed operand with two's-complement wrap at OUT_WIDTH.
module mixed_int_adder #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 32
) (
  input  logic [OUT_WIDTH-1:0] a,
  input  logic [IN_WIDTH-1:0]  b,
  output logic [OUT_WIDTH-1:0] sum
);

  logic [OUT_WIDTH-1:0] b_ext;

  // Sign bit is always the top bit of the short operand, whatever its width.
  assign b_ext = {{(OUT_WIDTH - IN_WIDTH){b[IN_WIDTH-1]}}, b};
  assign sum   = a + b_ext;

endmodule

// File: rtl/mixed_acc_sequencer.sv
// Accumulates a row of NumTerms signed short terms onto a wide signed bias
// using one shared mixed-width adder, with valid/ready on both sides.
// Optional build macro: MIXED_ACC_SATURATE_EN (clamp instead of wrap).
//
// state | meaning
// IDLE  | waiting for start_i; outputs hold last result
// ACCUM | accepting terms, one add per handshake
// DONE  | result presented until res_ready_i
module mixed_acc_sequencer
  import mixed_acc_pkg::*;
#(
  parameter int IN_WIDTH  = IN_WIDTH_DEF,
  parameter int OUT_WIDTH = OUT_WIDTH_DEF,
  parameter int NumTerms  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [OUT_WIDTH-1:0] bias_i,
  input  logic                 term_valid_i,
  output logic                 term_ready_o,
  input  logic [IN_WIDTH-1:0]  term_i,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [OUT_WIDTH-1:0] res_o,
  output logic                 busy_o,
  output logic                 ovf_o
);

  localparam int CntWidth = $clog2(NumTerms + 1);
  localparam logic [CntWidth-1:0] LastCnt = CntWidth'(NumTerms - 1);

  acc_state_e state, state_nxt;

  logic [OUT_WIDTH-1:0] acc, sum, acc_upd, res_q;
  logic [CntWidth-1:0]  cnt;
  logic                 ovf_q, ovf_add, hs, last_hs, start_cap, res_acc;

  mixed_int_adder #(
    .IN_WIDTH (IN_WIDTH),
    .OUT_WIDTH(OUT_WIDTH)
  ) u_add (
    .a  (acc),
    .b  (term_i),
    .sum(sum)
  );

  assign hs        = term_valid_i && term_ready_o;
  assign last_hs   = hs && (cnt == LastCnt);
  assign res_acc   = (state == DONE) && res_ready_i;
  // A new row can be captured from IDLE or in the same cycle a result is taken.
  assign start_cap = start_i && ((state == IDLE) || res_acc);

  // Overflow only possible when both operands share a sign and the sum flips it.
  assign ovf_add = (acc[OUT_WIDTH-1] == term_i[IN_WIDTH-1]) &&
                   (sum[OUT_WIDTH-1] != acc[OUT_WIDTH-1]);

`ifdef MIXED_ACC_SATURATE_EN
  localparam logic [63:0] SatMax64 = sat_max64(OUT_WIDTH);
  localparam logic [63:0] SatMin64 = sat_min64(OUT_WIDTH);

  // Clamp toward the direction of the operands when the add overflows.
  always_comb begin
    acc_upd = sum;
    if (ovf_add) begin
      acc_upd = acc[OUT_WIDTH-1] ? SatMin64[OUT_WIDTH-1:0] : SatMax64[OUT_WIDTH-1:0];
    end
  end
`else
  assign acc_upd = sum;
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = ACCUM;
      ACCUM:   if (last_hs) state_nxt = DONE;
      DONE:    if (res_ready_i) state_nxt = start_i ? ACCUM : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state only.
  always_comb begin
    term_ready_o = (state == ACCUM);
    res_valid_o  = (state == DONE);
    busy_o       = (state == ACCUM) || (state == DONE);
  end

  // Accumulator, term counter, sticky overflow and held result.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc   <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
      res_q <= '0;
    end else if (start_cap) begin
      acc   <= bias_i;
      cnt   <= '0;
      ovf_q <= 1'b0;
    end else if (hs) begin
      acc   <= acc_upd;
      cnt   <= cnt + CntWidth'(1);
      ovf_q <= ovf_q | ovf_add;
      if (last_hs) res_q <= acc_upd;
    end
  end

  assign res_o = res_q;
  assign ovf_o = ovf_q;

endmodule

// File: tb/tb_mixed_acc_sequencer.sv
// Self-checking bench for mixed_acc_sequencer with NumTerms=4.
module tb_mixed_acc_sequencer;

  localparam int NT = 4;
  localparam int IW = 8;
  localparam int OW = 32;
  localparam longint MAXV = (64'sd1 <<< (OW - 1)) - 64'sd1;
  localparam longint MINV = -(64'sd1 <<< (OW - 1));
  localparam longint SPAN = 64'sd1 <<< OW;

  logic          clk = 1'b0;
  logic          rst_n, start, term_valid, res_ready;
  logic [OW-1:0] bias;
  logic [IW-1:0] term;
  logic          term_ready, res_valid, busy, ovf;
  logic [OW-1:0] res;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mixed_acc_sequencer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .NumTerms(NT)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .bias_i      (bias),
    .term_valid_i(term_valid),
    .term_ready_o(term_ready),
    .term_i      (term),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_o       (res),
    .busy_o      (busy),
    .ovf_o       (ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer sum with per-step range check, then wrap or clamp.
  task automatic model(input logic [OW-1:0] b, input int t[NT],
                       output logic [OW-1:0] r, output logic o);
    longint a;
    a = longint'($signed(b));
    o = 1'b0;
    for (int i = 0; i < NT; i++) begin
      a = a + longint'(t[i]);
      if (a > MAXV || a < MINV) begin
        o = 1'b1;
`ifdef MIXED_ACC_SATURATE_EN
        a = (a > MAXV) ? MAXV : MINV;
`else
        a = (a > MAXV) ? a - SPAN : a + SPAN;
`endif
      end
    end
    r = a[OW-1:0];
  endtask

  task automatic start_row(input logic [OW-1:0] b);
    start = 1'b1;
    bias  = b;
    tick();
    start = 1'b0;
    bias  = $urandom;
    check("start_busy", OW'(busy), OW'(1));
    check("start_tready", OW'(term_ready), OW'(1));
  endtask

  // Feeds one row of terms; start_i and bias_i are scrambled to show they are ignored.
  task automatic feed(input logic [OW-1:0] b, input int t[NT], input bit rand_valid,
                      output logic [OW-1:0] exp_r);
    logic exp_o;
    int   i = 0;
    int   cyc = 0;
    bit   hs;
    model(b, t, exp_r, exp_o);
    while (i < NT && cyc < 200) begin
      term_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      term       = IW'(t[i]);
      start      = 1'($urandom_range(0, 1));
      bias       = $urandom;
      hs         = term_valid && term_ready;
      tick();
      if (hs) i++;
      if (hs && i < NT) check("mid_row_no_valid", OW'(res_valid), OW'(0));
      cyc++;
    end
    term_valid = 1'b0;
    start      = 1'b0;
    check("feed_all_terms", OW'(i), OW'(NT));
    check("res_valid_latency", OW'(res_valid), OW'(1));
    check("done_tready", OW'(term_ready), OW'(0));
    check("res_value", res, exp_r);
    check("ovf_flag", OW'(ovf), OW'(exp_o));
  endtask

  task automatic accept(input int hold, input logic [OW-1:0] exp_r,
                        input bit next, input logic [OW-1:0] next_bias);
    res_ready = 1'b0;
    for (int k = 0; k < hold; k++) begin
      term_valid = 1'($urandom_range(0, 1));
      tick();
      check("hold_res", res, exp_r);
      check("hold_valid", OW'(res_valid), OW'(1));
      check("hold_tready", OW'(term_ready), OW'(0));
    end
    term_valid = 1'b0;
    res_ready  = 1'b1;
    start      = next;
    bias       = next_bias;
    tick();
    res_ready = 1'b0;
    start     = 1'b0;
    check("after_acc_valid", OW'(res_valid), OW'(0));
    check("after_acc_busy", OW'(busy), OW'(next));
    check("after_acc_tready", OW'(term_ready), OW'(next));
    if (!next) check("idle_res_held", res, exp_r);
  endtask

  initial begin
    int            t[NT];
    logic [OW-1:0] er, b;
    bit            b2b;
    rst_n = 1'b0; start = 1'b0; term_valid = 1'b0; res_ready = 1'b0;
    bias = '0; term = '0;
    tick(); tick();
    check("rst_busy", OW'(busy), OW'(0));
    check("rst_tready", OW'(term_ready), OW'(0));
    check("rst_valid", OW'(res_valid), OW'(0));
    check("rst_res", res, OW'(0));
    check("rst_ovf", OW'(ovf), OW'(0));
    rst_n = 1'b1;
    tick();

    // Basic row: 100 + 1 - 2 + 3 - 4.
    start_row(OW'(100));
    t = '{1, -2, 3, -4};
    feed(OW'(100), t, 1'b0, er);
    check("basic_98", er, OW'(98));
    accept(0, er, 1'b0, '0);

    // Sign extension, long backpressure, then back-to-back start with bias 7.
    start_row(OW'(0));
    t = '{-128, -128, 127, -1};
    feed(OW'(0), t, 1'b1, er);
    check("sext_m130", er, OW'(-130));
    accept(5, er, 1'b1, OW'(7));
    t = '{10, -3, 0, 5};
    feed(OW'(7), t, 1'b1, er);
    check("b2b_19", er, OW'(19));
    accept(2, er, 1'b0, '0);

    // Overflow near the positive limit.
    start_row(32'h7FFF_FFF0);
    t = '{127, 127, 127, 127};
    feed(32'h7FFF_FFF0, t, 1'b0, er);
`ifdef MIXED_ACC_SATURATE_EN
    check("ovf_sat", er, 32'h7FFF_FFFF);
`else
    check("ovf_wrap", er, 32'h8000_01EC);
`endif
    accept(1, er, 1'b0, '0);

    // Reset after two of four terms.
    start_row(OW'(55));
    term_valid = 1'b1;
    term = IW'(20); tick();
    term = IW'(30); tick();
    term_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_busy", OW'(busy), OW'(0));
    check("mid_rst_tready", OW'(term_ready), OW'(0));
    check("mid_rst_valid", OW'(res_valid), OW'(0));
    check("mid_rst_res", res, OW'(0));
    check("mid_rst_ovf", OW'(ovf), OW'(0));
    tick();
    start_row(OW'(-5));
    t = '{1, 1, 1, 1};
    feed(OW'(-5), t, 1'b0, er);
    check("post_rst_m1", er, OW'(-1));
    accept(0, er, 1'b0, '0);

    // Random rows, some chained back-to-back.
    b = $urandom;
    start_row(b);
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < NT; i++) t[i] = int'($urandom_range(0, 255)) - 128;
      feed(b, t, 1'b1, er);
      b2b = (r < 11) && ($urandom_range(0, 1) == 1);
      b = (r % 3 == 0) ? 32'h7FFF_FF80 + OW'($urandom_range(0, 255)) : $urandom;
      accept($urandom_range(0, 3), er, b2b, b);
      if (!b2b && r < 11) start_row(b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
